// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path:
// opcodes, ALU function codes, datapath mux encodings, the controller
// state enum and the opcode-to-immediate-type helper.
package riscv_pkg;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_XOR   = 3'b111;

  // aluOp requests from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MDR       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Branch func3
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI, S_HALT
  } state_e;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opc);
    case (opc)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decoder.
// Ports:
//   aluOp      in  2  00 add, 01 sub, 10 decode func3/func7, 11 pass B
//   op         in  7  opcode (sub only exists for R-type)
//   func3      in  3  instruction func3
//   func7      in  7  instruction func7
//   ALUControl out 3  ALU function code
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD:   ALUControl = ALU_ADD;
      ALUOP_SUB:   ALUControl = ALU_SUB;
      ALUOP_PASSB: ALUControl = ALU_PASSB;
      default: begin
        case (func3)
          // func7 only selects sub for register-register ops; addi ignores it
          3'b000:  ALUControl = (op == OP_RTYPE && func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          3'b100:  ALUControl = ALU_XOR;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RISC-V datapath, plus a
// retired-instruction counter.
// Ports:
//   clk, rst (async active-low)
//   op/func3/func7  registered instruction fields; Zero/Neg ALU flags
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc, ALUControl  datapath controls
//   done         halted on an unsupported opcode
//   instr_count  retired instructions, wraps modulo 2^CNT_W
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             Zero,
  input  logic             Neg,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       alu_op;
  logic             retire;

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .ALUControl (ALUControl)
  );

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = imm_src_of(op);
    alu_op    = ALUOP_ADD;
    done      = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_START: begin
        ImmSrc  = IMM_I;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // branch/jal target precomputed into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MDR;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = (func3 == F3_BEQ &&  Zero) || (func3 == F3_BNE && !Zero) ||
                    (func3 == F3_BLT &&  Neg)  || (func3 == F3_BGE && !Neg);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // jumps to the DECODE-computed target while ALU makes the link value
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
        state_d   = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        ImmSrc  = IMM_U;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_PASSB;
        state_d = S_ALUWB;
      end
      S_HALT: begin
        ImmSrc = IMM_I;
        done   = 1'b1;
      end
    endcase
  end

  assign cnt_d       = retire ? cnt_q + CNT_W'(1) : cnt_q;
  assign instr_count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle
// tables derived from the instruction semantics, randomized instruction
// mix and flags, plus literal pins on selected cycles.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    op = '0;
  logic [2:0]    func3 = '0;
  logic [6:0]    func7 = '0;
  logic          Zero = 1'b0;
  logic          Neg = 1'b0;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, done;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]    ImmSrc, ALUControl;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .done(done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, alu;
    logic       done;
  } ctl_t;

  ctl_t dut_c;
  assign dut_c = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, done};

  int unsigned   n_chk = 0;
  int unsigned   n_pass = 0;
  logic [CW-1:0] cnt_m = '0;
  ctl_t          seen [8];
  logic [6:0]    legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic int unsigned cpi_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b1100011: return 3;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111: return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return (o == 7'b0110011 && f7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      3'd4:    return 3'b111;
      3'd2:    return 3'b101;
      3'd3:    return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // Expected controls for cycle k (0 = fetch) of an instruction.
  function automatic ctl_t model(input int unsigned k, input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input logic n);
    ctl_t e;
    e = '0;
    e.imm = imm_of(o);
    if (k == 0) begin
      e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
    end else if (k == 1) begin
      e.sa = 2'b01; e.sb = 2'b01;
    end else begin
      case (o)
        7'b0000011:
          if (k == 2)      begin e.sa = 2'b10; e.sb = 2'b01; end
          else if (k == 3) e.adr = 1'b1;
          else             begin e.rs = 2'b01; e.regw = 1'b1; end
        7'b0100011:
          if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
          else        begin e.adr = 1'b1; e.memw = 1'b1; end
        7'b0110011, 7'b0010011:
          if (k == 2) begin
            e.sa = 2'b10; e.sb = (o == 7'b0010011) ? 2'b01 : 2'b00; e.alu = alu_of(o, f3, f7);
          end else e.regw = 1'b1;
        7'b1100011: begin
          e.sa = 2'b10; e.alu = 3'b001;
          e.pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n);
        end
        7'b1101111:
          if (k == 2) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
          else        e.regw = 1'b1;
        7'b1100111:
          if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; end
          else        begin e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.regw = 1'b1; end
        7'b0110111:
          if (k == 2) begin e.sb = 2'b01; e.alu = 3'b100; end
          else        e.regw = 1'b1;
        default: begin e = '0; e.done = 1'b1; end
      endcase
    end
    return e;
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int unsigned ncyc, input bit frc, input bit fz, input bit fn);
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin op = o; func3 = f3; func7 = f7; end
      Zero = frc ? fz : (($urandom & 1) != 0);
      Neg  = frc ? fn : (($urandom & 1) != 0);
      #1;
      chk("ctl", 32'(dut_c), 32'(model(k, o, f3, f7, Zero, Neg)));
      chk("instr_count", 32'(instr_count), 32'(cnt_m));
      if (k < 8) seen[k] = dut_c;
    end
    if (cpi_of(o) != 0 && ncyc == cpi_of(o)) cnt_m = cnt_m + 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_ctl", 32'(dut_c), 32'h0);
    chk("reset_cnt", 32'(instr_count), 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("start_ctl", 32'(dut_c), 32'h0);

    // lw
    run_instr(7'b0000011, 3'b010, 7'h00, 5, 1'b0, 1'b0, 1'b0);
    chk("fetch_irw", 32'(seen[0].irw), 32'h1);
    chk("fetch_pcw", 32'(seen[0].pcw), 32'h1);
    chk("fetch_srcb", 32'(seen[0].sb), 32'h2);
    chk("lw_c4_regw", 32'(seen[3].regw), 32'h0);
    chk("lw_c5_regw", 32'(seen[4].regw), 32'h1);
    chk("lw_c5_rsrc", 32'(seen[4].rs), 32'h1);
    #6;
    chk("lw_count", 32'(instr_count), 32'h1);

    // ALU decode
    run_instr(7'b0110011, 3'b000, 7'b0100000, 4, 1'b0, 1'b0, 1'b0);
    chk("r_sub", 32'(seen[2].alu), 32'h1);
    run_instr(7'b0010011, 3'b000, 7'b0100000, 4, 1'b0, 1'b0, 1'b0);
    chk("i_add", 32'(seen[2].alu), 32'h0);
    run_instr(7'b0110011, 3'b011, 7'h00, 4, 1'b0, 1'b0, 1'b0);
    chk("r_sltu", 32'(seen[2].alu), 32'h6);

    // branches
    run_instr(7'b1100011, 3'b000, 7'h00, 3, 1'b1, 1'b1, 1'b0);
    chk("beq_z1", 32'(seen[2].pcw), 32'h1);
    run_instr(7'b1100011, 3'b001, 7'h00, 3, 1'b1, 1'b1, 1'b0);
    chk("bne_z1", 32'(seen[2].pcw), 32'h0);
    run_instr(7'b1100011, 3'b100, 7'h00, 3, 1'b1, 1'b0, 1'b1);
    chk("blt_n1", 32'(seen[2].pcw), 32'h1);
    run_instr(7'b1100011, 3'b101, 7'h00, 3, 1'b1, 1'b0, 1'b1);
    chk("bge_n1", 32'(seen[2].pcw), 32'h0);

    // jalr
    run_instr(7'b1100111, 3'b000, 7'h00, 4, 1'b0, 1'b0, 1'b0);
    chk("jalr_pcw", 32'(seen[2].pcw), 32'h1);
    chk("jalr_rsrc", 32'(seen[2].rs), 32'h2);
    chk("jalr_regw", 32'(seen[2].regw), 32'h0);
    chk("link_regw", 32'(seen[3].regw), 32'h1);
    chk("link_pcw", 32'(seen[3].pcw), 32'h0);
    chk("link_srca", 32'(seen[3].sa), 32'h1);
    chk("link_srcb", 32'(seen[3].sb), 32'h2);

    // random mix, long enough to wrap the 4-bit counter many times
    repeat (300) begin
      logic [6:0] o, f7;
      logic [2:0] f3;
      o  = legal_ops[$urandom_range(7)];
      f3 = 3'($urandom_range(7));
      f7 = (($urandom & 1) != 0) ? 7'b0100000 : 7'($urandom_range(127));
      run_instr(o, f3, f7, cpi_of(o), 1'b0, 1'b0, 1'b0);
    end

    // unsupported opcode
    run_instr(7'b0000000, 3'b000, 7'h00, 14, 1'b0, 1'b0, 1'b0);
    chk("halt_ctl", 32'(seen[7]), 32'h1);

    // reset in the middle of a store
    @(negedge clk); rst = 1'b0; #1;
    chk("halt_reset", 32'(dut_c), 32'h0);
    @(negedge clk); rst = 1'b1; cnt_m = '0;
    run_instr(7'b0100011, 3'b010, 7'h00, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("sw_memw", 32'(MemWrite), 32'h1);
    rst = 1'b0; #1;
    chk("abort_memw", 32'(MemWrite), 32'h0);
    chk("abort_ctl", 32'(dut_c), 32'h0);
    @(posedge clk); #1;
    chk("abort_cnt", 32'(instr_count), 32'h0);
    chk("abort_hold", 32'(dut_c), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
